// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the instruction/data memory port arbiter.
// Width codes, FSM states, port ids and the alignment check live here.
package mips_mem_pkg;

    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_WORD = 2'b10;
    localparam logic [1:0] W_RSVD = 2'b11;

    localparam logic P_IF = 1'b0;
    localparam logic P_DM = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    function automatic logic misaligned(input logic [1:0] addr_lo, input logic [1:0] width);
        logic bad_s;
        case (width)
            W_BYTE:  bad_s = 1'b0;
            W_HALF:  bad_s = addr_lo[0];
            W_WORD:  bad_s = |addr_lo;
            default: bad_s = 1'b0;
        endcase
        return bad_s;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection between the data and fetch ports.
// Data wins unless the fetch has already waited through STARVE_MAX data grants.
module mem_arb_pick
    import mips_mem_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int STREAK_W   = 3
) (
    input  logic                dm_req,
    input  logic                if_req,
    input  logic [STREAK_W-1:0] streak,
    output logic                grant_id,
    output logic                grant_valid
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_MAX);

    // Priority pick with starvation override.
    always_comb begin
        grant_valid = dm_req | if_req;
        if (if_req && (!dm_req || (streak == STREAK_MAX))) begin
            grant_id = P_IF;
        end else begin
            grant_id = P_DM;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch and data ports.
// One access at a time: IDLE grant -> BUSY for MEM_LATENCY cycles -> DONE ready pulse.
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1,
    parameter int STARVE_MAX  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [1:0]        dm_width,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              dm_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [1:0]        mem_width,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int STREAK_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0]    CNT_INIT   = CNT_W'(MEM_LATENCY - 1);
    localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
    localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_MAX);

    state_t              state_r, state_next_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [STREAK_W-1:0] streak_r, streak_next_s;
    logic                port_r, port_next_s;
    logic                grant_id_s, grant_valid_s, grant_s, grant_err_s, err_next_s, rd_done_s;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r, if_rdata_r, dm_rdata_r;
    logic                if_ready_r, dm_ready_r, dm_err_r, mem_en_r, mem_we_r;
    logic [1:0]          mem_width_r;

    mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX),
        .STREAK_W   (STREAK_W)
    ) u_pick (
        .dm_req      (dm_req),
        .if_req      (if_req),
        .streak      (streak_r),
        .grant_id    (grant_id_s),
        .grant_valid (grant_valid_s)
    );

    // Next-state, grant qualification and streak bookkeeping.
    always_comb begin
        state_next_s  = state_r;
        streak_next_s = streak_r;
        port_next_s   = port_r;
        grant_s       = 1'b0;
        grant_err_s   = 1'b0;
        err_next_s    = 1'b0;
        rd_done_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (grant_valid_s) begin
                    grant_s     = 1'b1;
                    port_next_s = grant_id_s;
                    if (grant_id_s == P_DM) begin
                        grant_err_s = (dm_width == W_RSVD) || misaligned(dm_addr[1:0], dm_width);
                        if (if_req) begin
                            streak_next_s = (streak_r == STREAK_MAX) ? streak_r : streak_r + STREAK_ONE;
                        end else begin
                            streak_next_s = {STREAK_W{1'b0}};
                        end
                    end else begin
                        streak_next_s = {STREAK_W{1'b0}};
                    end
                    err_next_s   = grant_err_s;
                    state_next_s = grant_err_s ? DONE : BUSY;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    rd_done_s    = 1'b1;
                    state_next_s = DONE;
                end else begin
                    state_next_s = BUSY;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, latched operands, memory-side strobes and per-port result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            streak_r    <= {STREAK_W{1'b0}};
            port_r      <= P_IF;
            addr_r      <= {ADDR_W{1'b0}};
            wdata_r     <= {DATA_W{1'b0}};
            if_rdata_r  <= {DATA_W{1'b0}};
            dm_rdata_r  <= {DATA_W{1'b0}};
            if_ready_r  <= 1'b0;
            dm_ready_r  <= 1'b0;
            dm_err_r    <= 1'b0;
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_width_r <= 2'b00;
        end else begin
            state_r  <= state_next_s;
            streak_r <= streak_next_s;
            port_r   <= port_next_s;
            if (grant_s) begin
                cnt_r <= CNT_INIT;
            end else if (state_r == BUSY) begin
                cnt_r <= cnt_r - CNT_ONE;
            end
            // Error requests never touch the memory side, so its operands stay put.
            if (grant_s && !grant_err_s) begin
                addr_r      <= (port_next_s == P_IF) ? if_addr : dm_addr;
                wdata_r     <= (port_next_s == P_DM) ? dm_wdata : wdata_r;
                mem_we_r    <= (port_next_s == P_DM) && dm_we;
                mem_width_r <= (port_next_s == P_DM) ? dm_width : W_WORD;
            end else if (state_next_s != BUSY) begin
                mem_we_r    <= 1'b0;
                mem_width_r <= 2'b00;
            end
            mem_en_r   <= (state_next_s == BUSY);
            if_ready_r <= (state_next_s == DONE) && (port_next_s == P_IF);
            dm_ready_r <= (state_next_s == DONE) && (port_next_s == P_DM);
            dm_err_r   <= (state_next_s == DONE) && err_next_s;
            if (rd_done_s && (port_r == P_IF)) begin
                if_rdata_r <= mem_rdata;
            end
            if (rd_done_s && (port_r == P_DM) && !mem_we_r) begin
                dm_rdata_r <= mem_rdata;
            end else if (grant_err_s && !dm_we) begin
                dm_rdata_r <= {DATA_W{1'b0}};
            end
        end
    end

    assign if_rdata  = if_rdata_r;
    assign if_ready  = if_ready_r;
    assign dm_rdata  = dm_rdata_r;
    assign dm_ready  = dm_ready_r;
    assign dm_err    = dm_err_r;
    assign mem_en    = mem_en_r;
    assign mem_we    = mem_we_r;
    assign mem_width = mem_width_r;
    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: two instances (latency 1 and 3) against a
// transaction-timeline reference model; memory returns valid data only on the last enable cycle.
module tb_mem_port_arbiter;
    import mips_mem_pkg::*;

    localparam int NI   = 2;
    localparam int SMAX = 4;
    localparam int M_FETCH = 0, M_GAP = 1, M_T3 = 2, M_STARVE = 3, M_RAND = 4;

    logic        clk;
    logic        rst_n     [NI];
    logic        if_req    [NI];
    logic [31:0] if_addr   [NI];
    logic [31:0] if_rdata  [NI];
    logic        if_ready  [NI];
    logic        dm_req    [NI];
    logic        dm_we     [NI];
    logic [1:0]  dm_width  [NI];
    logic [31:0] dm_addr   [NI];
    logic [31:0] dm_wdata  [NI];
    logic [31:0] dm_rdata  [NI];
    logic        dm_ready  [NI];
    logic        dm_err    [NI];
    logic        mem_en    [NI];
    logic        mem_we    [NI];
    logic [1:0]  mem_width [NI];
    logic [31:0] mem_addr  [NI];
    logic [31:0] mem_wdata [NI];
    logic [31:0] mem_rdata [NI];
    int          en_run    [NI];

    // Reference model state: one outstanding transaction per instance, described by its timeline.
    int          next_idle [NI], streak_m [NI], c_start [NI], c_ready [NI];
    bit          active [NI], c_port [NI], c_we [NI], c_err [NI], if_pend [NI], dm_pend [NI];
    logic [1:0]  c_width [NI];
    logic [31:0] c_addr [NI], c_wdata [NI], e_addr [NI], e_wdata [NI], e_if_rdata [NI], e_dm_rdata [NI];
    logic [31:0] seq_addr [NI];
    logic [9:0]  ord [NI];
    int          n_ord [NI];
    int          n_chk, n_err, cyc, rel_cyc, post_if;
    bit          rst_done;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mem_port_arbiter #(
            .ADDR_W      (32),
            .DATA_W      (32),
            .MEM_LATENCY ((g == 0) ? 1 : 3),
            .STARVE_MAX  (SMAX)
        ) dut (
            .clk       (clk),
            .reset     (rst_n[g]),
            .if_req    (if_req[g]),
            .if_addr   (if_addr[g]),
            .if_rdata  (if_rdata[g]),
            .if_ready  (if_ready[g]),
            .dm_req    (dm_req[g]),
            .dm_we     (dm_we[g]),
            .dm_width  (dm_width[g]),
            .dm_addr   (dm_addr[g]),
            .dm_wdata  (dm_wdata[g]),
            .dm_rdata  (dm_rdata[g]),
            .dm_ready  (dm_ready[g]),
            .dm_err    (dm_err[g]),
            .mem_en    (mem_en[g]),
            .mem_we    (mem_we[g]),
            .mem_width (mem_width[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_rdata (mem_rdata[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    function automatic int mode_of(input int t);
        if (t < 30) return M_FETCH;
        if (t < 36) return M_GAP;
        if (t < 50) return M_T3;
        if (t < 130) return M_STARVE;
        return M_RAND;
    endfunction

    // Memory model: junk until the final cycle of an enable run.
    always_comb begin
        for (int g = 0; g < NI; g++) begin
            if (en_run[g] == lat_of(g)) mem_rdata[g] = mem_word(mem_addr[g]);
            else mem_rdata[g] = ~mem_word(mem_addr[g]);
        end
    end

    task automatic chk(input string tag, input int g, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d cyc%0d: got %h expected %h", tag, g, cyc, got, exp);
        end
    endtask

    task automatic model_reset(input int g);
        active[g] = 1'b0; next_idle[g] = 0; streak_m[g] = 0;
        c_port[g] = 1'b0; c_we[g] = 1'b0; c_err[g] = 1'b0; c_width[g] = 2'b00;
        c_addr[g] = 32'h0; c_wdata[g] = 32'h0; c_start[g] = 0; c_ready[g] = 0;
        e_addr[g] = 32'h0; e_wdata[g] = 32'h0; e_if_rdata[g] = 32'h0; e_dm_rdata[g] = 32'h0;
        if_pend[g] = 1'b0; dm_pend[g] = 1'b0; en_run[g] = 0;
        if_req[g] = 1'b0; if_addr[g] = 32'h0;
        dm_req[g] = 1'b0; dm_we[g] = 1'b0; dm_width[g] = 2'b00; dm_addr[g] = 32'h0; dm_wdata[g] = 32'h0;
    endtask

    task automatic gen_if(input int g);
        case (mode_of(cyc))
            M_FETCH:  begin if_req[g] = 1'b1; if_addr[g] = seq_addr[g]; seq_addr[g] += 32'd4; end
            M_T3:     begin if_req[g] = (cyc == 36); if_addr[g] = 32'h0001_0100; end
            M_STARVE: begin if_req[g] = 1'b1; if_addr[g] = $urandom & 32'h0000_FFFC; end
            M_RAND:   begin if_req[g] = ($urandom_range(0, 3) != 0); if_addr[g] = $urandom & 32'h0000_FFFC; end
            default:  if_req[g] = 1'b0;
        endcase
        if (g == 1 && cyc == rel_cyc) if_req[g] = 1'b1;
        if_pend[g] = if_req[g];
    endtask

    task automatic gen_dm(input int g);
        dm_wdata[g] = $urandom;
        case (mode_of(cyc))
            M_T3: begin
                dm_req[g]   = (cyc == 36) || (cyc == 46);
                dm_we[g]    = (cyc == 46);
                dm_width[g] = (cyc == 46) ? W_HALF : W_WORD;
                dm_addr[g]  = (cyc == 46) ? 32'h0002_0001 : 32'h0002_0000;
            end
            M_STARVE: begin
                dm_req[g] = 1'b1; dm_we[g] = $urandom_range(0, 1) != 0;
                dm_width[g] = W_WORD; dm_addr[g] = $urandom & 32'h0003_FFFC;
            end
            M_RAND: begin
                dm_req[g] = ($urandom_range(0, 2) != 0); dm_we[g] = $urandom_range(0, 1) != 0;
                dm_width[g] = 2'($urandom_range(0, 3)); dm_addr[g] = $urandom & 32'h0003_FFFF;
            end
            default: dm_req[g] = 1'b0;
        endcase
        if (g == 1 && cyc == rel_cyc) dm_req[g] = 1'b0;
        dm_pend[g] = dm_req[g];
    endtask

    task automatic step(input int g);
        bit busy_e, rdy_e, pick_if;
        busy_e = active[g] && !c_err[g] && cyc >= c_start[g] && cyc < c_start[g] + lat_of(g);
        rdy_e  = active[g] && cyc == c_ready[g];
        if (busy_e && cyc == c_start[g]) begin e_addr[g] = c_addr[g]; e_wdata[g] = c_wdata[g]; end
        if (rdy_e && c_port[g] == P_IF) e_if_rdata[g] = mem_word(c_addr[g]);
        else if (rdy_e && !c_we[g]) e_dm_rdata[g] = c_err[g] ? 32'h0 : mem_word(c_addr[g]);
        chk("mem_en", g, mem_en[g], busy_e);
        chk("mem_we", g, mem_we[g], busy_e && c_we[g]);
        chk("mem_width", g, mem_width[g], busy_e ? c_width[g] : 2'b00);
        chk("mem_addr", g, mem_addr[g], e_addr[g]);
        chk("mem_wdata", g, mem_wdata[g], e_wdata[g]);
        chk("if_ready", g, if_ready[g], rdy_e && c_port[g] == P_IF);
        chk("dm_ready", g, dm_ready[g], rdy_e && c_port[g] == P_DM);
        chk("dm_err", g, dm_err[g], rdy_e && c_err[g]);
        chk("if_rdata", g, if_rdata[g], e_if_rdata[g]);
        chk("dm_rdata", g, dm_rdata[g], e_dm_rdata[g]);
        en_run[g] = mem_en[g] ? en_run[g] + 1 : 0;
        if (rdy_e) begin
            if (cyc > 50 && cyc <= 130 && n_ord[g] < 10) begin
                ord[g] = {ord[g][8:0], c_port[g] == P_IF};
                n_ord[g]++;
            end
            if (g == 1 && rst_done && c_port[g] == P_IF) post_if++;
            if (c_port[g] == P_IF) if_pend[g] = 1'b0;
            else dm_pend[g] = 1'b0;
            active[g] = 1'b0;
        end
        if (!rst_n[g]) return;
        // Operands of the port being served are fair game once latched.
        if (active[g] && c_port[g] == P_IF) if_addr[g] = $urandom;
        if (active[g] && c_port[g] == P_DM) begin
            dm_addr[g] = $urandom; dm_wdata[g] = $urandom; dm_we[g] = ~dm_we[g]; dm_width[g] = ~dm_width[g];
        end
        if (!if_pend[g]) gen_if(g);
        if (!dm_pend[g]) gen_dm(g);
        if (cyc >= next_idle[g] && (if_req[g] || dm_req[g])) begin
            pick_if = if_req[g] && (!dm_req[g] || streak_m[g] == SMAX);
            if (pick_if || !if_req[g]) streak_m[g] = 0;
            else if (streak_m[g] < SMAX) streak_m[g]++;
            c_port[g]  = pick_if ? P_IF : P_DM;
            c_we[g]    = !pick_if && dm_we[g];
            c_width[g] = pick_if ? W_WORD : dm_width[g];
            c_addr[g]  = pick_if ? if_addr[g] : dm_addr[g];
            c_wdata[g] = pick_if ? e_wdata[g] : dm_wdata[g];
            c_err[g]   = !pick_if && ((dm_width[g] == W_RSVD) || (dm_width[g] == W_HALF && dm_addr[g][0])
                         || (dm_width[g] == W_WORD && dm_addr[g][1:0] != 2'b00));
            c_start[g]   = cyc + 1;
            c_ready[g]   = c_err[g] ? cyc + 1 : cyc + lat_of(g) + 1;
            next_idle[g] = c_ready[g] + 1;
            active[g]    = 1'b1;
        end
    endtask

    initial begin
        n_chk = 0; n_err = 0; cyc = 0; rel_cyc = -1; post_if = 0; rst_done = 1'b0;
        for (int g = 0; g < NI; g++) begin
            rst_n[g] = 1'b0;
            model_reset(g);
            seq_addr[g] = 32'h0001_0000;
            ord[g] = 10'b0;
            n_ord[g] = 0;
        end
        for (int t = 0; t < 1500; t++) begin
            @(negedge clk);
            cyc = t;
            if (t == 2) begin rst_n[0] = 1'b1; rst_n[1] = 1'b1; end
            if (t == rel_cyc) rst_n[1] = 1'b1;
            for (int g = 0; g < NI; g++) step(g);
            if (t >= 300 && !rst_done && active[1] && !c_err[1] && t == c_start[1] + 1) begin
                #2;
                rst_n[1] = 1'b0;
                #1;
                chk("rst_mem_en", 1, mem_en[1], 1'b0);
                chk("rst_if_ready", 1, if_ready[1], 1'b0);
                chk("rst_dm_ready", 1, dm_ready[1], 1'b0);
                model_reset(1);
                rst_done = 1'b1;
                rel_cyc = t + 3;
            end
        end
        for (int g = 0; g < NI; g++) begin
            chk("starve_order", g, ord[g], 10'b00001_00001);
            chk("starve_count", g, n_ord[g], 10);
        end
        chk("rst_window", 1, rst_done, 1'b1);
        chk("post_rst_fetch", 1, post_if > 0, 1'b1);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
